// File: rtl/fetch_queue_alpha.sv
// fetch_queue_alpha: fetch stage feeding alpha decode. Owns the PC, drives the
// SRAM-like instruction port, buffers returned words in order and applies
// MIPS delay-slot rules on redirects from decode.
// Optional build macro FETCH_BYPASS_EN: a response arriving while the queue is
// empty is presented to decode in the same cycle.
module fetch_queue_alpha #(
  parameter int          QDEPTH   = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redir_req,
  input  logic [31:0] redir_addr,
  input  logic        redir_no_slot,
  input  logic        d_ready,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_addr_err_if,
  output logic        f_in_delay_slot,
  output logic        f_is_instr
);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {RUN, SLOT_WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;

  // Outstanding requests, oldest at index 0. keep=0 marks a response that is
  // to be thrown away (wrong path); slot=1 marks the delay-slot word.
  logic [31:0] rq_pc   [MAX_OUT];
  logic        rq_keep [MAX_OUT];
  logic        rq_slot [MAX_OUT];
  logic [31:0] sh_pc   [MAX_OUT];
  logic        sh_keep [MAX_OUT];
  logic        sh_slot [MAX_OUT];
  logic [OW-1:0] rq_cnt;
  logic [OW-1:0] rem;

  // Instruction queue (circular buffer).
  logic [31:0] q_pc    [QDEPTH];
  logic [31:0] q_instr [QDEPTH];
  logic        q_err   [QDEPTH];
  logic        q_slot  [QDEPTH];
  logic        q_isi   [QDEPTH];
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [CW-1:0] count;

  logic resp, resp_keep, resp_q, deq_q, accept, wr_resp, wr_err;
  logic kill_all, slot_redir, keep_next, resp_slot, pend_slot, to_wait;

  assign resp      = inst_data_ok && (rq_cnt != '0);
  assign resp_keep = resp && rq_keep[0];
  assign rem       = rq_cnt - OW'(resp);
  assign tail      = head + QW'(count);
  assign deq_q     = d_ready && (count != '0);

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp    = resp_keep && (count == '0);
  assign resp_q = resp_keep && !(byp && d_ready);
`else
  assign resp_q = resp_keep;
`endif

  // A redirect suppresses the request so the bus never sees a dropped address accepted.
  assign inst_req  = !rst && !redir_req && (state != HOLD) && (pc[1:0] == 2'b00) &&
                     (int'(rq_cnt) < MAX_OUT) && ((int'(count) + int'(rq_cnt)) < QDEPTH);
  assign inst_addr = pc;
  assign accept    = inst_req && inst_addr_ok;

  // Misaligned PC: wait for the bus to drain, then queue one error entry.
  assign wr_err = !redir_req && (state != HOLD) && (pc[1:0] != 2'b00) &&
                  (rq_cnt == '0) && (int'(count) < QDEPTH);

  // Redirect classification: the branch at the head leaves this cycle.
  assign kill_all   = redir_req && (redir_no_slot || state == SLOT_WAIT);
  assign slot_redir = redir_req && !kill_all;
  assign keep_next  = slot_redir && (int'(count) >= 2);
  assign resp_slot  = slot_redir && !keep_next && resp_q;
  assign pend_slot  = slot_redir && !keep_next && !resp_q && (rem != '0);
  assign to_wait    = slot_redir && !keep_next && !resp_q && (rem == '0);
  assign wr_resp    = resp_q && (!redir_req || resp_slot);

  // Head presentation; fields read as zero when nothing is valid.
  always_comb begin
    f_valid         = 1'b0;
    f_pc            = '0;
    f_instr         = '0;
    f_addr_err_if   = 1'b0;
    f_in_delay_slot = 1'b0;
    f_is_instr      = 1'b0;
    if (count != '0) begin
      f_valid         = 1'b1;
      f_pc            = q_pc[head];
      f_instr         = q_instr[head];
      f_addr_err_if   = q_err[head];
      f_in_delay_slot = q_slot[head];
      f_is_instr      = q_isi[head];
    end
`ifdef FETCH_BYPASS_EN
    else if (byp) begin
      f_valid         = 1'b1;
      f_pc            = rq_pc[0];
      f_instr         = inst_rdata;
      f_in_delay_slot = rq_slot[0];
      f_is_instr      = 1'b1;
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUT; gi++) begin : g_rq
      // Shift the request FIFO down by one when a response retires its oldest entry.
      if (gi == MAX_OUT - 1) begin : g_last
        assign sh_pc[gi]   = resp ? '0   : rq_pc[gi];
        assign sh_keep[gi] = resp ? 1'b0 : rq_keep[gi];
        assign sh_slot[gi] = resp ? 1'b0 : rq_slot[gi];
      end else begin : g_mid
        assign sh_pc[gi]   = resp ? rq_pc[gi+1]   : rq_pc[gi];
        assign sh_keep[gi] = resp ? rq_keep[gi+1] : rq_keep[gi];
        assign sh_slot[gi] = resp ? rq_slot[gi+1] : rq_slot[gi];
      end

      // Per-entry update: shift, append on accept, retag on redirect.
      always_ff @(posedge clk) begin
        if (rst) begin
          rq_keep[gi] <= 1'b0;
          rq_slot[gi] <= 1'b0;
        end else begin
          rq_pc[gi]   <= sh_pc[gi];
          rq_keep[gi] <= sh_keep[gi];
          rq_slot[gi] <= sh_slot[gi];
          if (accept && rem == OW'(gi)) begin
            rq_pc[gi]   <= pc;
            rq_keep[gi] <= 1'b1;
            rq_slot[gi] <= (state == SLOT_WAIT);
          end
          if (kill_all || keep_next || resp_slot) begin
            rq_keep[gi] <= 1'b0;
          end else if (pend_slot) begin
            rq_keep[gi] <= (gi == 0);
            if (gi == 0) rq_slot[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Queue storage writes: returned words, error entries, and slot marking.
  always_ff @(posedge clk) begin
    if (wr_resp || wr_err) begin
      q_pc[tail]    <= wr_err ? pc : rq_pc[0];
      q_instr[tail] <= wr_err ? 32'h0 : inst_rdata;
      q_err[tail]   <= wr_err;
      q_isi[tail]   <= !wr_err;
      q_slot[tail]  <= !wr_err && (rq_slot[0] || resp_slot);
    end
    if (keep_next) q_slot[head + QW'(1)] <= 1'b1;
  end

  // Control FSM: PC, state, queue pointers and outstanding count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      tgt    <= '0;
      head   <= '0;
      count  <= '0;
      rq_cnt <= '0;
    end else begin
      rq_cnt <= rem + OW'(accept);
      if (redir_req) begin
        if (to_wait) begin
          tgt   <= redir_addr;
          state <= SLOT_WAIT;
        end else begin
          pc    <= redir_addr;
          state <= RUN;
        end
        if (keep_next) begin
          head  <= head + QW'(1);
          count <= CW'(1);
        end else if (resp_slot) begin
          head  <= tail;
          count <= CW'(1);
        end else begin
          count <= '0;
        end
      end else begin
        if (accept) begin
          if (state == SLOT_WAIT) begin
            pc    <= tgt;
            state <= RUN;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        if (wr_err) state <= HOLD;
        head  <= head + QW'(deq_q);
        count <= count + CW'(wr_resp || wr_err) - CW'(deq_q);
      end
    end
  end

  // A response with nothing outstanding breaks the bus protocol; it is dropped.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(inst_data_ok && rq_cnt == '0));
  end
endmodule
